// File: rtl/immediate_encoding_unit.sv
// rtl/immediate_encoding_unit.sv - two-stage RV32IM instruction encoder with immediate range checking
module immediate_encoding_unit #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [2:0]             select_i,
    input  logic [6:0]             opcode_i,
    input  logic [4:0]             rd_i,
    input  logic [4:0]             rs1_i,
    input  logic [4:0]             rs2_i,
    input  logic [2:0]             funct3_i,
    input  logic [6:0]             funct7_i,
    input  logic [31:0]            immediate_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            instruction_o,
    output logic                   error_o,
    output logic [1:0]             error_code_o,
    output logic [COUNT_WIDTH-1:0] encoded_count_o,
    output logic [COUNT_WIDTH-1:0] error_count_o
);
    localparam logic [2:0]  SEL_U = 3'b000;
    localparam logic [2:0]  SEL_J = 3'b001;
    localparam logic [2:0]  SEL_I = 3'b010;
    localparam logic [2:0]  SEL_B = 3'b011;
    localparam logic [2:0]  SEL_S = 3'b100;
    localparam logic [2:0]  SEL_R = 3'b101;
    localparam logic [1:0]  ERR_NONE    = 2'b00;
    localparam logic [1:0]  ERR_RANGE   = 2'b01;
    localparam logic [1:0]  ERR_ALIGN   = 2'b10;
    localparam logic [1:0]  ERR_ILLEGAL = 2'b11;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

    logic                   s1_valid_q;
    logic [2:0]             s1_sel_q;
    logic [6:0]             s1_opcode_q;
    logic [4:0]             s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]             s1_funct3_q;
    logic [6:0]             s1_funct7_q;
    logic [31:0]            s1_imm_q;
    logic [1:0]             s1_code_q, s1_code_d;

    logic                   out_valid_q;
    logic [31:0]            instr_q, instr_d;
    logic                   error_q;
    logic [1:0]             code_q;
    logic [COUNT_WIDTH-1:0] enc_cnt_q, enc_cnt_d;
    logic [COUNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic s2_adv, s1_adv, in_xfer, out_xfer;

    assign s2_adv   = !out_valid_q || out_ready_i;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_xfer  = in_valid_i && s1_adv;
    assign out_xfer = out_valid_q && out_ready_i;

    // A sign-extended field fits when every bit above it equals its sign bit.
    always_comb begin
        s1_code_d = ERR_NONE;
        case (select_i)
            SEL_U: if (|immediate_i[11:0]) s1_code_d = ERR_ALIGN;
            SEL_J: begin
                if (immediate_i[0])
                    s1_code_d = ERR_ALIGN;
                else if (!(&immediate_i[31:20] || !(|immediate_i[31:20])))
                    s1_code_d = ERR_RANGE;
            end
            SEL_I, SEL_S: begin
                if (!(&immediate_i[31:11] || !(|immediate_i[31:11])))
                    s1_code_d = ERR_RANGE;
            end
            SEL_B: begin
                if (immediate_i[0])
                    s1_code_d = ERR_ALIGN;
                else if (!(&immediate_i[31:12] || !(|immediate_i[31:12])))
                    s1_code_d = ERR_RANGE;
            end
            SEL_R:   s1_code_d = ERR_NONE;
            default: s1_code_d = ERR_ILLEGAL;
        endcase
    end

    always_comb begin
        instr_d = NOP_WORD;
        case (s1_sel_q)
            SEL_U: instr_d = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
            SEL_J: instr_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                              s1_rd_q, s1_opcode_q};
            SEL_I: instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            SEL_S: instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                              s1_imm_q[4:0], s1_opcode_q};
            SEL_B: instr_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                              s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
            SEL_R: instr_d = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            default: instr_d = NOP_WORD;
        endcase
        if (s1_code_q != ERR_NONE)
            instr_d = NOP_WORD;
    end

    always_comb begin
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (out_xfer) begin
            if (!error_q && enc_cnt_q != CNT_MAX) enc_cnt_d = enc_cnt_q + COUNT_WIDTH'(1);
            if (error_q && err_cnt_q != CNT_MAX)  err_cnt_d = err_cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            error_q     <= 1'b0;
            code_q      <= ERR_NONE;
            enc_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (s1_adv)
                s1_valid_q <= in_valid_i;
            if (in_xfer) begin
                s1_sel_q    <= select_i;
                s1_opcode_q <= opcode_i;
                s1_rd_q     <= rd_i;
                s1_rs1_q    <= rs1_i;
                s1_rs2_q    <= rs2_i;
                s1_funct3_q <= funct3_i;
                s1_funct7_q <= funct7_i;
                s1_imm_q    <= immediate_i;
                s1_code_q   <= s1_code_d;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    instr_q <= instr_d;
                    error_q <= (s1_code_q != ERR_NONE);
                    code_q  <= s1_code_q;
                end
            end
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign in_ready_o      = s1_adv;
    assign out_valid_o     = out_valid_q;
    assign instruction_o   = instr_q;
    assign error_o         = error_q;
    assign error_code_o    = code_q;
    assign encoded_count_o = enc_cnt_q;
    assign error_count_o   = err_cnt_q;
endmodule

// File: doc/immediate_encoding_unit.md
# immediate_encoding_unit

Pipelined RV32IM instruction encoder, the inverse of the decode-stage immediate generator. It accepts a format select, register/function fields and a 32-bit immediate value, and produces the 32-bit instruction word with immediate bits scattered per format. It also checks that each immediate is representable. It serves the instruction-memory preload path and the self-test program builder, and connects through valid/ready handshakes on both sides.

## Interface

- COUNT_WIDTH, 16: width of the saturating statistics counters.

- CLK  input  1  single clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  request valid.
- IN_READY  output  1  unit can accept a request this cycle.
- SELECT  input  3  format: 000 U, 001 J, 010 I, 011 B, 100 S, 101 R; 110/111 illegal.
- OPCODE  input  7  instruction[6:0].
- RD, RS1, RS2  input  5 each  register fields.
- FUNCT3  input  3  function field.
- FUNCT7  input  7  function field, used for R only.
- IMMEDIATE  input  32  immediate value, in the form the decoder reproduces.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts the result.
- INSTRUCTION  output  32  encoded word.
- ERROR  output  1  result carries an error.
- ERROR_CODE  output  2  00 none, 01 range, 10 misaligned, 11 illegal select.
- ENCODED_COUNT  output  COUNT_WIDTH  number of error-free results delivered.
- ERROR_COUNT  output  COUNT_WIDTH  number of errored results delivered.

## Operation

- Handshakes:
  - A transfer occurs on an edge where both VALID and READY are high.
  - All request fields are sampled only on an input transfer.
- Stage 1 registers the accepted request and classifies it:
  - U: IMMEDIATE[11:0] must be zero, else misaligned.
  - J: bit 0 must be zero; IMMEDIATE[31:20] must be all equal.
  - I and S: IMMEDIATE[31:11] must be all equal.
  - B: bit 0 must be zero; IMMEDIATE[31:12] must be all equal.
  - R: IMMEDIATE is ignored and never errors.
  - Error precedence: illegal select > misaligned > range.
- Stage 2 builds the instruction word:
  - U: {imm[31:12], RD, OPCODE}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], RD, OPCODE}.
  - I: {imm[11:0], RS1, FUNCT3, RD, OPCODE}.
  - S: {imm[11:5], RS2, RS1, FUNCT3, imm[4:0], OPCODE}.
  - B: {imm[12], imm[10:5], RS2, RS1, FUNCT3, imm[4:1], imm[11], OPCODE}.
  - R: {FUNCT7, RS2, RS1, FUNCT3, RD, OPCODE}.
- Errored result: INSTRUCTION = 32'h00000013 (NOP), ERROR = 1 with the code. An errored result still occupies a slot and is still handshaken out.
- Round-trip property: for any non-errored I/S/B/U/J result, decoding INSTRUCTION with the same SELECT returns IMMEDIATE exactly.
- Counters:
  - On each output transfer, ENCODED_COUNT increments if ERROR = 0, else ERROR_COUNT increments.
  - Both saturate at all-ones and never wrap.
- Ordering: results are delivered strictly in request order; nothing is dropped or duplicated.

## Timing

- Reset: on an edge with RESET high, the following clear to 0:
  - both stage valids;
  - OUT_VALID, INSTRUCTION, ERROR, ERROR_CODE;
  - both counters.
  - IN_READY reads 1 in the cycle after reset.
  - Any input transfer on a reset edge is ignored.
- Reset mid-stream discards all in-flight requests. No output transfer is counted on the reset edge.
- Latency: a request accepted on edge k appears on the outputs after edge k+1. OUT_VALID is high in the cycle between edges k+1 and k+2.
- Throughput: one request per cycle while OUT_READY is high.
- Stall logic:
  - Stage 2 advances when !OUT_VALID || OUT_READY.
  - Stage 1 advances when it is empty or stage 2 advances.
  - IN_READY = stage 1 advances. It is combinational from OUT_READY; no other combinational input-to-output paths exist.
- Hold rule: while OUT_VALID = 1 and OUT_READY = 0, INSTRUCTION, ERROR and ERROR_CODE hold stable.
- Full condition: with both stages occupied and OUT_READY low, IN_READY = 0. Exactly two requests are buffered.
- Simultaneous events: in-transfer and out-transfer on the same edge with both stages full is legal. The pipeline shifts and stays full.

## Test plan

- I-type: SELECT 010, OPCODE 0010011, RD 1, RS1 0, FUNCT3 0, IMMEDIATE FFFFFFFF, accepted edge k -> INSTRUCTION FFF00093, ERROR 0, OUT_VALID after edge k+1, ENCODED_COUNT 1.
- B-type: SELECT 011, OPCODE 1100011, RS1 1, RS2 2, FUNCT3 0, IMMEDIATE FFFFFFFC -> FE208EE3. J-type: SELECT 001, OPCODE 1101111, RD 1, IMMEDIATE 00000800 -> 001000EF.
- Errors, checked individually:
  - SELECT 010, IMMEDIATE 00000800 -> ERROR_CODE 01, INSTRUCTION 00000013.
  - SELECT 011, IMMEDIATE 00000003 -> code 10.
  - SELECT 111 -> code 11.
  - After the three, ERROR_COUNT 3 and ENCODED_COUNT unchanged.
- Backpressure: stream 4 back-to-back requests with OUT_READY low for 3 cycles -> IN_READY drops after 2 held, outputs stay stable, then all 4 emerge in order with no loss.
- Reset mid-stream: RESET high one edge with 2 requests in flight -> OUT_VALID 0, counters 0, next request completes normally with 2-edge latency.
- Random round-trip: 10,000 legal requests through this unit and the decoder -> immediate and fields match; counter saturation checked with COUNT_WIDTH 4 (holds at 15).
